// File: rtl/mux_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_sel_pkg
// Description : Shared definitions for the six-way mux select arbiter:
//               source count, FSM state type and the per-source select
//               codes driven onto {sel1,sel2,sel3,sel4,sel5}.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_sel_pkg;

  localparam int NSRC = 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // {sel1,sel2,sel3,sel4,sel5}; mux don't-care positions are tied to 0
  localparam logic [4:0] SEL_A = 5'b10000;
  localparam logic [4:0] SEL_B = 5'b01100;
  localparam logic [4:0] SEL_C = 5'b01000;
  localparam logic [4:0] SEL_D = 5'b00100;
  localparam logic [4:0] SEL_E = 5'b00010;
  localparam logic [4:0] SEL_F = 5'b00000;

  function automatic logic [4:0] sel_of(input logic [2:0] idx);
    logic [4:0] s;
    case (idx)
      3'd0:    s = SEL_A;
      3'd1:    s = SEL_B;
      3'd2:    s = SEL_C;
      3'd3:    s = SEL_D;
      3'd4:    s = SEL_E;
      default: s = SEL_F;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_sel_arbiter_rr_pick6.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick6
// Description : Combinational round-robin picker. Returns the first set
//               request bit found searching upward from ptr, wrapping 5->0.
// Ports       : req    [5:0] in  - request per source
//               ptr    [2:0] in  - search start index (0..5)
//               winner [2:0] out - selected source index (0 if none)
//               any          out - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick6
  import mux_sel_pkg::*;
(
  input  logic [NSRC-1:0] req,
  input  logic [2:0]      ptr,
  output logic [2:0]      winner,
  output logic            any
);

  logic [2:0] w_start;
  logic [3:0] w_idx;

  always_comb begin
    // ptr never leaves 0..5; out-of-range values fall back to a search from 0
    w_start = (ptr < 3'd6) ? ptr : 3'd0;
    w_idx   = 4'd0;
    winner  = 3'd0;
    any     = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      w_idx = {1'b0, w_start} + 4'(k);
      if (w_idx >= 4'd6) begin
        w_idx = w_idx - 4'd6;
      end
      if (!any && req[w_idx[2:0]]) begin
        any    = 1'b1;
        winner = w_idx[2:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_sel_arbiter
// Description : Round-robin arbiter driving the selects of the six-way
//               4-bit priority mux. Grants one source at a time, encodes the
//               winner onto sel1..sel5 and flags a valid mux output.
//               Build option MUXSEL_HOLD_EN: when defined, a grant tenure is
//               limited to HOLD_CYCLES cycles; when undefined, the owner keeps
//               the grant for as long as it requests.
// Ports       : clk            in  - rising-edge clock
//               rst_n          in  - asynchronous active-low reset
//               req      [5:0] in  - request per source (bit0=a .. bit5=f)
//               grant    [5:0] out - one-hot registered grant, 0 when idle
//               sel1..sel5     out - registered mux selects
//               g_valid        out - mux output carries a granted source
//               owner    [2:0] out - current grant holder, 0 when idle
// Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] req,
  output logic [NSRC-1:0] grant,
  output logic            sel1,
  output logic            sel2,
  output logic            sel3,
  output logic            sel4,
  output logic            sel5,
  output logic            g_valid,
  output logic [2:0]      owner
);

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_owner, w_owner_nxt;
  logic [2:0]      r_ptr, w_ptr_nxt;
  logic [NSRC-1:0] r_grant, w_grant_nxt;
  logic [4:0]      r_sel, w_sel_nxt;
  logic            r_gvalid, w_gvalid_nxt;

  logic [2:0]      w_rel_ptr;
  logic [2:0]      w_pick_ptr;
  logic [2:0]      w_winner;
  logic            w_any;
  logic            w_keep;

  // Search start on release is owner+1, which leaves the releasing owner
  // competing last; from IDLE the stored pointer is used.
  assign w_rel_ptr  = (r_owner == 3'd5) ? 3'd0 : r_owner + 3'd1;
  assign w_pick_ptr = (r_state == GRANT) ? w_rel_ptr : r_ptr;

  rr_pick6 u_pick (
    .req    (req),
    .ptr    (w_pick_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

`ifdef MUXSEL_HOLD_EN
  localparam logic [3:0] c_hold_last = 4'(HOLD_CYCLES - 1);

  logic [3:0] r_cnt, w_cnt_nxt;

  assign w_keep = req[r_owner] && (r_cnt < c_hold_last);

  // Counter only advances while the same tenure continues; any new grant,
  // including a re-grant to the sole requester, starts again from 0.
  assign w_cnt_nxt = ((r_state == GRANT) && w_keep) ? r_cnt + 4'd1 : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_keep = req[r_owner];

  logic w_unused_hold;
  assign w_unused_hold = ^4'(HOLD_CYCLES);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_ptr_nxt    = r_ptr;
    w_grant_nxt  = r_grant;
    w_sel_nxt    = r_sel;
    w_gvalid_nxt = r_gvalid;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt  = GRANT;
          w_owner_nxt  = w_winner;
          w_grant_nxt  = {{(NSRC-1){1'b0}}, 1'b1} << w_winner;
          w_sel_nxt    = sel_of(w_winner);
          w_gvalid_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (!w_keep) begin
          w_ptr_nxt = w_rel_ptr;
          if (w_any) begin
            // Hand over on the same edge, no idle bubble
            w_owner_nxt  = w_winner;
            w_grant_nxt  = {{(NSRC-1){1'b0}}, 1'b1} << w_winner;
            w_sel_nxt    = sel_of(w_winner);
            w_gvalid_nxt = 1'b1;
          end else begin
            w_state_nxt  = IDLE;
            w_owner_nxt  = 3'd0;
            w_grant_nxt  = '0;
            w_sel_nxt    = 5'b00000;
            w_gvalid_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_owner_nxt  = 3'd0;
        w_grant_nxt  = '0;
        w_sel_nxt    = 5'b00000;
        w_gvalid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= 3'd0;
      r_ptr    <= 3'd0;
      r_grant  <= '0;
      r_sel    <= 5'b00000;
      r_gvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_ptr    <= w_ptr_nxt;
      r_grant  <= w_grant_nxt;
      r_sel    <= w_sel_nxt;
      r_gvalid <= w_gvalid_nxt;
    end
  end

  assign grant   = r_grant;
  assign sel1    = r_sel[4];
  assign sel2    = r_sel[3];
  assign sel3    = r_sel[2];
  assign sel4    = r_sel[1];
  assign sel5    = r_sel[0];
  assign g_valid = r_gvalid;
  assign owner   = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_sel_arbiter
// Description : Self-checking bench for mux_sel_arbiter: directed vector
//               table, hand-written reset/rotation/sole-requester sequences
//               and random requests against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;

  localparam int HOLD = 4;
`ifdef MUXSEL_HOLD_EN
  localparam int LIMIT = HOLD;
`else
  localparam int LIMIT = 0;  // 0 means tenure is unlimited
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] req = 6'b0;
  logic [5:0] grant;
  logic       sel1, sel2, sel3, sel4, sel5;
  logic       g_valid;
  logic [2:0] owner;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .grant   (grant),
    .sel1    (sel1),
    .sel2    (sel2),
    .sel3    (sel3),
    .sel4    (sel4),
    .sel5    (sel5),
    .g_valid (g_valid),
    .owner   (owner)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the grant, for how many cycles so far,
  // and where the next search starts.
  int m_active, m_owner, m_held, m_ptr;

  typedef struct {
    logic [5:0] req;
    logic [5:0] grant;
    logic [4:0] sel;
    logic [2:0] owner;
    logic       gv;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [4:0] exp_sel(input int idx);
    case (idx)
      0:       return 5'b10000;
      1:       return 5'b01100;
      2:       return 5'b01000;
      3:       return 5'b00100;
      4:       return 5'b00010;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic int first_from(input logic [5:0] r, input int p);
    for (int k = 0; k < 6; k++) begin
      if (r[(p + k) % 6]) return (p + k) % 6;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_owner = 0; m_held = 0; m_ptr = 0;
  endtask

  task automatic model_step(input logic [5:0] r);
    if (m_active == 0) begin
      if (r != 0) begin
        m_owner = first_from(r, m_ptr); m_active = 1; m_held = 1;
      end
    end else if (r[m_owner] && (LIMIT == 0 || m_held < LIMIT)) begin
      m_held++;
    end else begin
      m_ptr = (m_owner + 1) % 6;
      if (r != 0) begin
        m_owner = first_from(r, m_ptr); m_held = 1;
      end else begin
        m_active = 0;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_sel();
    return int'({sel1, sel2, sel3, sel4, sel5});
  endfunction

  task automatic check_model(input string tag);
    logic [5:0] eg;
    eg = (m_active != 0) ? (6'b000001 << m_owner) : 6'b0;
    check({tag, ".grant"}, int'(grant), int'(eg));
    check({tag, ".sel"}, dut_sel(), (m_active != 0) ? int'(exp_sel(m_owner)) : 0);
    check({tag, ".owner"}, int'(owner), (m_active != 0) ? m_owner : 0);
    check({tag, ".gvalid"}, int'(g_valid), m_active);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".grant"}, int'(grant), 0);
    check({tag, ".sel"}, dut_sel(), 0);
    check({tag, ".owner"}, int'(owner), 0);
    check({tag, ".gvalid"}, int'(g_valid), 0);
  endtask

  // Advance one edge and sample 1 time unit later; the model follows the
  // request value the DUT saw on that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) model_step(req);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();

    // ---- Reset with all sources requesting ----
    req = 6'b111111;
    tick();
    check_zero("rst_hold0");
    tick();
    check_zero("rst_hold1");
    rst_n = 1'b1;
    tick();
    check("rst_rel.grant", int'(grant), 1);
    check("rst_rel.sel", dut_sel(), 5'b10000);
    check("rst_rel.owner", int'(owner), 0);

    // ---- Rotation with all requests steady ----
    for (int i = 1; i < 30; i++) begin
      tick();
      check("rot.owner", int'(owner), (LIMIT > 0) ? (i / LIMIT) % 6 : 0);
      check("rot.gvalid", int'(g_valid), 1);
      check_model("rot");
    end

    // ---- Directed vector table from a fresh reset ----
    tbl[0] = '{6'b000100, 6'b000100, 5'b01000, 3'd2, 1'b1};
    tbl[1] = '{6'b010100, 6'b000100, 5'b01000, 3'd2, 1'b1};
    tbl[2] = '{6'b010000, 6'b010000, 5'b00010, 3'd4, 1'b1};
    tbl[3] = '{6'b000000, 6'b000000, 5'b00000, 3'd0, 1'b0};
    tbl[4] = '{6'b000011, 6'b000001, 5'b10000, 3'd0, 1'b1};
    tbl[5] = '{6'b000010, 6'b000010, 5'b01100, 3'd1, 1'b1};
    tbl[6] = '{6'b001010, 6'b000010, 5'b01100, 3'd1, 1'b1};
    tbl[7] = '{6'b001000, 6'b001000, 5'b00100, 3'd3, 1'b1};
    tbl[8] = '{6'b100000, 6'b100000, 5'b00000, 3'd5, 1'b1};
    tbl[9] = '{6'b000000, 6'b000000, 5'b00000, 3'd0, 1'b0};
    req = 6'b0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req;
      tick();
      check($sformatf("vec%0d.grant", i), int'(grant), int'(tbl[i].grant));
      check($sformatf("vec%0d.sel", i), dut_sel(), int'(tbl[i].sel));
      check($sformatf("vec%0d.owner", i), int'(owner), int'(tbl[i].owner));
      check($sformatf("vec%0d.gvalid", i), int'(g_valid), int'(tbl[i].gv));
    end

    // ---- Sole requester keeps the grant ----
    req = 6'b100000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("sole.grant", int'(grant), 6'b100000);
      check("sole.sel", dut_sel(), 0);
      check("sole.gvalid", int'(g_valid), 1);
    end

    // ---- Idle return ----
    req = 6'b000000;
    tick();
    check_zero("idle");

    // ---- Reset asserted mid-tenure ----
    req = 6'b001000;
    tick();
    check("pre_rst.owner", int'(owner), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    tick();
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    check("post_rst.owner", int'(owner), 3);
    check("post_rst.grant", int'(grant), 6'b001000);
    check_model("post_rst");

    // ---- Random requests against the model ----
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0:       req = 6'($urandom);
        1:       req = 6'($urandom) & 6'($urandom);
        2:       req = req ^ (6'b000001 << $urandom_range(0, 5));
        default: req = req;
      endcase
      tick();
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
